mips_run_ctrl: RTL and testbench

Synthesizable run controller that sits between the top-level clock/reset and the MIPS single-cycle core. It sequences the core's reset, gates execution with a pause control, counts executed cycles, and stops the core on a programmable cycle limit, a halt-PC match, or a detected self-loop. It reports why execution ended, replacing the fixed "stop after N negedges" count with a parametrised, reusable block.

---
 rtl/mips_run_ctrl.sv | 155 +++++++++++++++
 tb/tb_mips_run_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS single-cycle core: reset sequencing, pause gating, cycle counting
// and stop detection (limit, halt PC, self-loop). Self-loop check built only with MIPS_RUN_CTRL_LOOP_DETECT_EN.
module mips_run_ctrl #(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned PC_W         = 32,
   parameter int unsigned MAX_CYCLES   = 18,
   parameter int unsigned RESET_CYCLES = 1,
   parameter int unsigned LOOP_LIMIT   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             ack,
   input  logic [PC_W-1:0]  halt_pc,
   input  logic [PC_W-1:0]  pc,
   input  logic             pc_valid,
   output logic             core_rst_n,
   output logic             core_en,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             busy,
   output logic             done,
   output logic [1:0]       cause
);

   localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

   typedef enum logic [2:0] {StIdle, StHold, StRun, StPause, StDone} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
   logic [1:0]          cause_q, cause_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                run_en, halt_hit, loop_hit, limit_hit, run_start;

   assign run_en    = (state_q == StRun) && !pause;
   assign run_start = (state_q == StIdle) && start;

`ifdef MIPS_RUN_CTRL_LOOP_DETECT_EN
   localparam int unsigned LOOP_W = $clog2(LOOP_LIMIT + 1);
   localparam logic [LOOP_W-1:0] LOOP_MAX = LOOP_W'(LOOP_LIMIT);

   logic [PC_W-1:0]   prev_q, prev_d;
   logic [LOOP_W-1:0] loop_q, loop_d, loop_nxt;

   // loop_q == 0 marks "no valid PC seen yet this run", so a stale prev_q never counts
   always_comb begin
      loop_d   = loop_q;
      prev_d   = prev_q;
      loop_nxt = ((loop_q != '0) && (pc == prev_q)) ? loop_q + 1'b1 : LOOP_W'(1);
      if (run_start) begin
         loop_d = '0;
      end else if (run_en && pc_valid) begin
         loop_d = loop_nxt;
         prev_d = pc;
      end
   end

   assign loop_hit = pc_valid && (loop_nxt == LOOP_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loop_q <= '0;
         prev_q <= '0;
      end else begin
         loop_q <= loop_d;
         prev_q <= prev_d;
      end
   end
`else
   assign loop_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cause_d    = cause_q;
      hold_d     = hold_q;
      core_rst_n = 1'b1;
      core_en    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      halt_hit   = pc_valid && (pc == halt_pc);
      limit_hit  = (MAX_CYCLES != 0) && (cnt_inc == MAX_C);
      unique case (state_q)
         StIdle: begin
            core_rst_n = 1'b0;
            if (start) begin
               state_d = StHold;
               cnt_d   = '0;
               cause_d = 2'b00;
               hold_d  = '0;
            end
         end
         StHold: begin
            core_rst_n = 1'b0;
            busy       = 1'b1;
            if (hold_q == HOLD_LAST) begin
               state_d = StRun;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         StRun: begin
            busy    = 1'b1;
            core_en = run_en;
            if (pause) begin
               state_d = StPause;
            end else begin
               cnt_d = cnt_inc;
               if (halt_hit) begin
                  state_d = StDone;
                  cause_d = 2'b10;
               end else if (loop_hit) begin
                  state_d = StDone;
                  cause_d = 2'b11;
               end else if (limit_hit) begin
                  state_d = StDone;
                  cause_d = 2'b01;
               end
            end
         end
         StPause: begin
            busy = 1'b1;
            if (!pause) state_d = StRun;
         end
         StDone: begin
            done = 1'b1;
            if (ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         cause_q <= 2'b00;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         hold_q  <= hold_d;
      end
   end

   assign cycle_cnt = cnt_q;
   assign cause     = cause_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: runs push expected {cause, count, latency}; a monitor
// pops and compares whenever done rises.
module tb_mips_run_ctrl;

   logic        clk, rst, start, pause, ack, pc_valid;
   logic [31:0] halt_pc, pc;
   logic        core_rst_n, core_en, busy, done;
   logic [31:0] cycle_cnt;
   logic [1:0]  cause;

   typedef struct {
      logic [1:0]  cause;
      logic [31:0] cnt;
      int          start_cyc;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic done_seen = 1'b0;

   mips_run_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .ack        (ack),
      .halt_pc    (halt_pc),
      .pc         (pc),
      .pc_valid   (pc_valid),
      .core_rst_n (core_rst_n),
      .core_en    (core_en),
      .cycle_cnt  (cycle_cnt),
      .busy       (busy),
      .done       (done),
      .cause      (cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Raise start for one edge; that edge is cyc+1
   task automatic do_start(input logic [1:0] c, input logic [31:0] n, input int lat);
      exp_t e;
      e.cause = c;
      e.cnt = n;
      e.start_cyc = cyc + 1;
      e.lat = lat;
      exp_q.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      if (!done) begin
         n_fail++;
         $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", budget);
      end
   endtask

   task automatic do_ack;
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done && !done_seen) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
               e = exp_q.pop_front();
               check("sb_cause", 64'(cause), 64'(e.cause));
               check("sb_cycle_cnt", 64'(cycle_cnt), 64'(e.cnt));
               check("sb_core_en_in_done", 64'(core_en), 64'd0);
               if (e.lat >= 0) check("sb_latency", 64'(cyc - e.start_cyc), 64'(e.lat));
            end
         end
         done_seen = done;
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; ack = 1'b0;
      pc_valid = 1'b0; pc = '0; halt_pc = 32'hFFFF_FFF0;
      #3;
      check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
      check("rst_core_en", 64'(core_en), 64'd0);
      check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cause", 64'(cause), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Limit stop
      do_start(2'b01, 32'd18, 19);
      check("hold_core_rst_n", 64'(core_rst_n), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
      tick();
      check("run_core_rst_n", 64'(core_rst_n), 64'd1);
      check("run_core_en", 64'(core_en), 64'd1);
      wait_done(40);
      do_ack();
      check("ack_idle_busy", 64'(busy), 64'd0);
      check("ack_idle_done", 64'(done), 64'd0);
      check("ack_idle_cnt_held", 64'(cycle_cnt), 64'd18);

      // Halt PC: pc 0,4,8,... matches 0x20 on the 9th cycle
      halt_pc = 32'h20;
      pc_valid = 1'b1;
      do_start(2'b10, 32'd9, 10);
      pc = 32'h0;
      tick();
      for (int i = 1; i < 14 && !done; i++) begin
         tick();
         pc = 32'(4 * i);
      end
      wait_done(5);
      pc_valid = 1'b0;
      do_ack();

      // Self-loop: 0,4,8,8,8,8
      halt_pc = 32'hFFFF_FFF0;
      pc_valid = 1'b1;
`ifdef MIPS_RUN_CTRL_LOOP_DETECT_EN
      do_start(2'b11, 32'd6, 7);
`else
      do_start(2'b01, 32'd18, 19);
`endif
      pc = 32'h0;
      tick();
      for (int i = 1; i < 30 && !done; i++) begin
         tick();
         pc = (i < 2) ? 32'(4 * i) : 32'h8;
      end
      wait_done(5);
      pc_valid = 1'b0;
      do_ack();

      // Pause for 5 cycles after 5 enabled cycles
      do_start(2'b01, 32'd18, -1);
      tick();
      repeat (5) tick();
      pause = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("pause_core_en", 64'(core_en), 64'd0);
         check("pause_cnt_frozen", 64'(cycle_cnt), 64'd5);
         tick();
      end
      pause = 1'b0;
      wait_done(40);
      do_ack();

      // Priority: halt_pc coincides with the 18th (limit) cycle
      halt_pc = 32'h100;
      do_start(2'b10, 32'd18, 19);
      tick();
      repeat (17) tick();
      pc_valid = 1'b1;
      pc = 32'h100;
      tick();
      pc_valid = 1'b0;
      wait_done(5);
      ack = 1'b1;
      start = 1'b1;
      tick();
      ack = 1'b0;
      start = 1'b0;
      check("ackstart_busy", 64'(busy), 64'd0);
      check("ackstart_done", 64'(done), 64'd0);
      check("idle_cnt_held", 64'(cycle_cnt), 64'd18);
      check("idle_cause_held", 64'(cause), 64'd2);
      tick();
      check("ackstart_still_idle", 64'(busy), 64'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_cnt_clear", 64'(cycle_cnt), 64'd0);
      check("restart_cause_clear", 64'(cause), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);

      // Async reset mid-RUN
      tick();
      repeat (3) tick();
      check("pre_rst_core_en", 64'(core_en), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("async_core_rst_n", 64'(core_rst_n), 64'd0);
      check("async_core_en", 64'(core_en), 64'd0);
      check("async_busy", 64'(busy), 64'd0);
      check("async_done", 64'(done), 64'd0);
      check("async_cause", 64'(cause), 64'd0);
      check("async_cycle_cnt", 64'(cycle_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
